abacus_seq_alu: RTL and testbench

ABACUS_SEQ_ALU -- requirements
Module: abacus_seq_alu

---
 rtl/abacus_seq_alu.sv | 244 ++++++++++++++++++++++++
 tb/tb_abacus_seq_alu.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/abacus_seq_alu.sv
// Sequential add/sub/mul/div unit with an optional double-dabble BCD stage.
// Define ABACUS_BCD_EN to build the CONV state and bcd output; otherwise bcd is tied to 0.
module abacus_seq_alu #(
    parameter int unsigned W      = 8,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [W-1:0]          a,
    input  logic [W-1:0]          b,
    output logic                  busy,
    output logic                  done,
    output logic [2*W-1:0]        result,
    output logic [W-1:0]          rem,
    output logic                  neg,
    output logic                  dbz,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned CntW = $clog2(2 * W + 1);
    localparam logic [CntW-1:0] CntCalcLast = CntW'(W - 1);

    localparam logic [1:0] OpAdd = 2'b00;
    localparam logic [1:0] OpSub = 2'b01;
    localparam logic [1:0] OpMul = 2'b10;
    localparam logic [1:0] OpDiv = 2'b11;

    typedef enum logic [1:0] {StIdle, StCalc, StConv, StDone} state_t;

`ifdef ABACUS_BCD_EN
    localparam state_t PostCalc = StConv;
    localparam logic [CntW-1:0] CntConvLast = CntW'(2 * W - 1);
`else
    localparam state_t PostCalc = StDone;
`endif

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [W-1:0]        a_q, a_d;
    logic [W-1:0]        b_q, b_d;
    logic [2*W-1:0]      work_q, work_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [2*W-1:0]      result_q, result_d;
    logic [W-1:0]        rem_q, rem_d;
    logic                neg_q, neg_d;
    logic                dbz_q, dbz_d;

    logic [W:0]          add_sum;
    logic [W-1:0]        sub_abs;
    logic [W:0]          mul_sum;
    logic [2*W-1:0]      mul_next;
    logic [W:0]          div_shift;
    logic                div_ge;
    logic [W-1:0]        div_rem;
    logic [2*W-1:0]      div_next;

    assign add_sum = {1'b0, a_q} + {1'b0, b_q};
    assign sub_abs = (a_q < b_q) ? (b_q - a_q) : (a_q - b_q);

    // Shift-add: upper half accumulates, multiplier bits retire from the low end.
    assign mul_sum  = {1'b0, work_q[2*W-1:W]} + (work_q[0] ? {1'b0, b_q} : '0);
    assign mul_next = {mul_sum, work_q[W-1:1]};

    // Restoring divide: work holds {partial remainder, dividend/quotient}.
    assign div_shift = work_q[2*W-1:W-1];
    assign div_ge    = div_shift >= {1'b0, b_q};
    assign div_rem   = div_ge ? (div_shift[W-1:0] - b_q) : div_shift[W-1:0];
    assign div_next  = {div_rem, work_q[W-2:0], div_ge};

`ifdef ABACUS_BCD_EN
    logic [2*W-1:0]        bin_q, bin_d;
    logic [4*DIGITS-1:0]   dig_q, dig_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic [4*DIGITS-5:0]   low_adj;
    logic [3:0]            top_dig;
    logic [2:0]            top_adj;
    logic [4*DIGITS-1:0]   dig_shift;

    // Top digit never overflows, so only its low three adjusted bits survive the shift.
    always_comb begin
        low_adj = '0;
        for (int i = 0; i < int'(DIGITS) - 1; i++) begin
            low_adj[4*i +: 4] = (dig_q[4*i +: 4] >= 4'd5) ? dig_q[4*i +: 4] + 4'd3
                                                          : dig_q[4*i +: 4];
        end
        top_dig   = dig_q[4*DIGITS-1 -: 4];
        top_adj   = (top_dig >= 4'd5) ? top_dig[2:0] + 3'd3 : top_dig[2:0];
        dig_shift = {top_adj, low_adj, bin_q[2*W-1]};
    end

    assign bcd = bcd_q;
`else
    assign bcd = '0;
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        rem_d    = rem_q;
        neg_d    = neg_q;
        dbz_d    = dbz_q;
`ifdef ABACUS_BCD_EN
        bin_d    = bin_q;
        dig_d    = dig_q;
        bcd_d    = bcd_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    work_d  = {{W{1'b0}}, a};
                    cnt_d   = '0;
                    neg_d   = 1'b0;
                    dbz_d   = 1'b0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                unique case (op_q)
                    OpAdd: begin
                        result_d = {{(W-1){1'b0}}, add_sum};
                        rem_d    = '0;
                        state_d  = PostCalc;
                    end
                    OpSub: begin
                        result_d = {{W{1'b0}}, sub_abs};
                        neg_d    = a_q < b_q;
                        rem_d    = '0;
                        state_d  = PostCalc;
                    end
                    OpMul: begin
                        work_d = mul_next;
                        cnt_d  = cnt_q + CntW'(1);
                        if (cnt_q == CntCalcLast) begin
                            result_d = mul_next;
                            rem_d    = '0;
                            state_d  = PostCalc;
                        end
                    end
                    OpDiv: begin
                        if (b_q == '0) begin
                            dbz_d    = 1'b1;
                            result_d = {{W{1'b0}}, {W{1'b1}}};
                            rem_d    = a_q;
                            state_d  = PostCalc;
                        end else begin
                            work_d = div_next;
                            cnt_d  = cnt_q + CntW'(1);
                            if (cnt_q == CntCalcLast) begin
                                result_d = {{W{1'b0}}, div_next[W-1:0]};
                                rem_d    = div_next[2*W-1:W];
                                state_d  = PostCalc;
                            end
                        end
                    end
                endcase
`ifdef ABACUS_BCD_EN
                if (state_d == StConv) begin
                    bin_d = result_d;
                    dig_d = '0;
                    cnt_d = '0;
                end
`endif
            end
            StConv: begin
`ifdef ABACUS_BCD_EN
                dig_d = dig_shift;
                bin_d = {bin_q[2*W-2:0], 1'b0};
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntConvLast) begin
                    bcd_d   = dig_shift;
                    state_d = StDone;
                end
`else
                state_d = StIdle;
`endif
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= StIdle;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            rem_q    <= '0;
            neg_q    <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            neg_q    <= neg_d;
            dbz_q    <= dbz_d;
        end
    end

`ifdef ABACUS_BCD_EN
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            bin_q <= '0;
            dig_q <= '0;
            bcd_q <= '0;
        end else begin
            bin_q <= bin_d;
            dig_q <= dig_d;
            bcd_q <= bcd_d;
        end
    end
`endif

    assign busy   = state_q != StIdle;
    assign done   = state_q == StDone;
    assign result = result_q;
    assign rem    = rem_q;
    assign neg    = neg_q;
    assign dbz    = dbz_q;

endmodule

// File: tb/tb_abacus_seq_alu.sv
// Directed self-checking bench for abacus_seq_alu (W=8, DIGITS=5), either ABACUS_BCD_EN build.
module tb_abacus_seq_alu;

    localparam int W      = 8;
    localparam int DIGITS = 5;
`ifdef ABACUS_BCD_EN
    localparam int  ConvCyc = 2 * W;
    localparam bit  BcdOn   = 1'b1;
`else
    localparam int  ConvCyc = 0;
    localparam bit  BcdOn   = 1'b0;
`endif
    localparam int LatShort = 1 + ConvCyc + 1;
    localparam int LatLong  = W + ConvCyc + 1;

    logic                clk;
    logic                clr_n;
    logic                start;
    logic [1:0]          op;
    logic [W-1:0]        a;
    logic [W-1:0]        b;
    logic                busy;
    logic                done;
    logic [2*W-1:0]      result;
    logic [W-1:0]        rem;
    logic                neg;
    logic                dbz;
    logic [4*DIGITS-1:0] bcd;

    int n_cmp = 0;
    int n_err = 0;

    abacus_seq_alu #(
        .W      (W),
        .DIGITS (DIGITS)
    ) dut (
        .clk    (clk),
        .clr_n  (clr_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rem    (rem),
        .neg    (neg),
        .dbz    (dbz),
        .bcd    (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch one operation, scramble operands after acceptance, then check latency and outputs.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] va,
                          input logic [W-1:0] vb, input int exp_lat,
                          input logic [31:0] exp_res, input logic [31:0] exp_rem,
                          input logic exp_neg, input logic exp_dbz, input logic [31:0] exp_bcd);
        int  lat;
        bit  got;
        @(negedge clk);
        op    = o;
        a     = va;
        b     = vb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~va;
        b     = vb + 8'd3;
        op    = ~o;
        check({tag, ".busy"}, 32'(busy), 32'd1);
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk);
            #1;
            lat = i + 2;
            got = done;
        end
        if (!got) begin
            check({tag, ".timeout_done"}, 32'd0, 32'd1);
        end else begin
            check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
            check({tag, ".result"}, 32'(result), exp_res);
            check({tag, ".rem"}, 32'(rem), exp_rem);
            check({tag, ".neg"}, 32'(neg), 32'(exp_neg));
            check({tag, ".dbz"}, 32'(dbz), 32'(exp_dbz));
            check({tag, ".bcd"}, 32'(bcd), BcdOn ? exp_bcd : 32'd0);
            @(posedge clk);
            #1;
            check({tag, ".done_pulse"}, 32'({done, busy}), 32'd0);
        end
    endtask

    int dones;
    int captured;

    initial begin
        clr_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        #12;
        check("reset.busy_done", 32'({busy, done}), 32'd0);
        check("reset.result", 32'(result), 32'd0);
        check("reset.flags", 32'({rem, neg, dbz}), 32'd0);
        check("reset.bcd", 32'(bcd), 32'd0);
        @(negedge clk);
        clr_n = 1'b1;

        run_op("add200_100", 2'b00, 8'd200, 8'd100, LatShort, 300, 0, 1'b0, 1'b0, 32'h00300);
        run_op("sub50_200", 2'b01, 8'd50, 8'd200, LatShort, 150, 0, 1'b1, 1'b0, 32'h00150);
        run_op("sub77_77", 2'b01, 8'd77, 8'd77, LatShort, 0, 0, 1'b0, 1'b0, 32'h00000);
        run_op("mul255_255", 2'b10, 8'd255, 8'd255, LatLong, 65025, 0, 1'b0, 1'b0, 32'h65025);
        run_op("div200_7", 2'b11, 8'd200, 8'd7, LatLong, 28, 4, 1'b0, 1'b0, 32'h00028);
        run_op("div200_0", 2'b11, 8'd200, 8'd0, LatShort, 255, 200, 1'b0, 1'b1, 32'h00255);
        run_op("add255_255", 2'b00, 8'd255, 8'd255, LatShort, 510, 0, 1'b0, 1'b0, 32'h00510);
        run_op("mul13_11", 2'b10, 8'd13, 8'd11, LatLong, 143, 0, 1'b0, 1'b0, 32'h00143);
        run_op("div255_16", 2'b11, 8'd255, 8'd16, LatLong, 15, 15, 1'b0, 1'b0, 32'h00015);

        // Outputs must hold while idle regardless of inputs.
        @(negedge clk);
        a  = 8'd1;
        b  = 8'd1;
        op = 2'b00;
        repeat (5) @(posedge clk);
        #1;
        check("hold.result_rem", 32'({result, rem}), {8'd0, 16'd15, 8'd15});

        // start held high with changing operands through a multiply.
        @(negedge clk);
        op    = 2'b10;
        a     = 8'd12;
        b     = 8'd10;
        start = 1'b1;
        dones = 0;
        captured = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                captured = 32'(result);
            end
            if (dones > 0 && !done) start = 1'b0;
            else begin
                a = 8'($urandom);
                b = 8'($urandom);
            end
        end
        start = 1'b0;
        check("stream.done_count", 32'(dones), 32'd1);
        check("stream.result_at_done", 32'(captured), 32'd120);
        check("stream.result_held", 32'(result), 32'd120);
        check("stream.idle", 32'(busy), 32'd0);

        // Reset mid-operation (mid-CONV when BCD is built, mid-CALC otherwise).
        @(negedge clk);
        op    = 2'b10;
        a     = 8'd255;
        b     = 8'd255;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (BcdOn ? 12 : 4) @(posedge clk);
        #2;
        check("abort.busy_before", 32'(busy), 32'd1);
        clr_n = 1'b0;
        #1;
        check("abort.busy_done", 32'({busy, done}), 32'd0);
        check("abort.result", 32'(result), 32'd0);
        check("abort.flags", 32'({rem, neg, dbz}), 32'd0);
        check("abort.bcd", 32'(bcd), 32'd0);
        @(negedge clk);
        clr_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("abort.no_done", 32'(dones), 32'd0);
        run_op("add1_2", 2'b00, 8'd1, 8'd2, LatShort, 3, 0, 1'b0, 1'b0, 32'h00003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
